// File: rtl/branch_resolve_bht_pkg.sv
// Shared definitions for the branch resolution unit: branch funct3 codes,
// 2-bit counter encodings and helpers for BHT indexing and counter update.
package branch_resolve_bht_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  // Saturating step of a bimodal counter toward the observed outcome.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == ST) ? ST : cnt + 2'd1;
    end else begin
      nxt = (cnt == SNT) ? SNT : cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_cmp.sv
// Combinational XLEN-generic conditional-branch compare built on a single
// (XLEN+1)-bit subtraction; flags the reserved funct3 codes as illegal.
module branch_cmp
  import branch_resolve_bht_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int FUNCT3 = 3
) (
  input  logic [FUNCT3-1:0] funct3,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic              taken,
  output logic              illegal
);

  logic            signed_s;
  logic [XLEN:0]   a_s;
  logic [XLEN:0]   b_s;
  logic [XLEN:0]   diff_s;
  logic            lt_s;
  logic            eq_s;
  logic            unused_diff_s;

  // funct3[1] separates the unsigned pair (BLTU/BGEU) from the signed pair.
  assign signed_s      = ~funct3[1];
  assign a_s           = {signed_s & rs1[XLEN-1], rs1};
  assign b_s           = {signed_s & rs2[XLEN-1], rs2};
  assign diff_s        = a_s - b_s;
  assign lt_s          = diff_s[XLEN];
  assign eq_s          = (rs1 == rs2);
  assign unused_diff_s = ^diff_s[XLEN-1:0];

  // Outcome decode by branch condition
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BEQ:         taken = eq_s;
      BNE:         taken = ~eq_s;
      BLT, BLTU:   taken = lt_s;
      BGE, BGEU:   taken = ~lt_s;
      default: begin
        taken   = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolution unit with a bimodal BHT: combinational fetch-side
// prediction, one-cycle registered resolve, mispredict flag and statistics.
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FUNCT3    = 3,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_LSB   = 2,
  parameter int CNT_W     = 32
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_taken,
  input  logic              En,
  input  logic [FUNCT3-1:0] funct3,
  input  logic [XLEN-1:0]   Rs1,
  input  logic [XLEN-1:0]   Rs2,
  input  logic [XLEN-1:0]   res_pc,
  input  logic              res_pred,
  output logic              res_valid,
  output logic              Branch_taken,
  output logic              mispredict,
  output logic              illegal,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX_W = idx_width(BHT_DEPTH);

  logic [1:0]       bht_r [BHT_DEPTH];
  logic [IDX_W-1:0] pred_idx_s;
  logic [IDX_W-1:0] res_idx_s;
  logic [1:0]       pred_entry_s;
  logic             taken_s;
  logic             illegal_s;
  logic             next_bt_s;
  logic             next_mp_s;
  logic             res_valid_r;
  logic             branch_taken_r;
  logic             mispredict_r;
  logic             illegal_r;
  logic [CNT_W-1:0] branch_cnt_r;
  logic [CNT_W-1:0] mispred_cnt_r;
  logic             unused_pc_s;

  assign pred_idx_s   = pred_pc[IDX_LSB +: IDX_W];
  assign res_idx_s    = res_pc[IDX_LSB +: IDX_W];
  assign unused_pc_s  = ^{pred_pc, res_pc};
  // Lookup reads the stored state only, so a same-index update is not bypassed.
  assign pred_entry_s = bht_r[pred_idx_s];
  assign pred_taken   = pred_entry_s[1];

  branch_cmp #(
    .XLEN   (XLEN),
    .FUNCT3 (FUNCT3)
  ) u_cmp (
    .funct3  (funct3),
    .rs1     (Rs1),
    .rs2     (Rs2),
    .taken   (taken_s),
    .illegal (illegal_s)
  );

  // Result values to capture; illegal requests report not-taken, no mispredict
  always_comb begin
    next_bt_s = 1'b0;
    next_mp_s = 1'b0;
    if (illegal_s) begin
      next_bt_s = 1'b0;
      next_mp_s = 1'b0;
    end else begin
      next_bt_s = taken_s;
      next_mp_s = taken_s ^ res_pred;
    end
  end

  // Result registers, BHT update and statistics counters
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r    <= 1'b0;
      branch_taken_r <= 1'b0;
      mispredict_r   <= 1'b0;
      illegal_r      <= 1'b0;
      branch_cnt_r   <= {CNT_W{1'b0}};
      mispred_cnt_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_r[i] <= WNT;
      end
    end else begin
      res_valid_r <= En;
      if (En) begin
        branch_taken_r <= next_bt_s;
        mispredict_r   <= next_mp_s;
        illegal_r      <= illegal_s;
        if (!illegal_s) begin
          bht_r[res_idx_s] <= sat_update(bht_r[res_idx_s], taken_s);
          branch_cnt_r     <= branch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (next_mp_s) begin
            mispred_cnt_r <= mispred_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

  assign res_valid    = res_valid_r;
  assign Branch_taken = branch_taken_r;
  assign mispredict   = mispredict_r;
  assign illegal      = illegal_r;
  assign branch_cnt   = branch_cnt_r;
  assign mispred_cnt  = mispred_cnt_r;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scoreboard bench for branch_resolve_bht: a reference model predicts each
// resolve result and the BHT state; results are popped and compared on output.
module tb_branch_resolve_bht;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic [31:0]   pred_pc;
  logic          pred_taken;
  logic          En;
  logic [2:0]    funct3;
  logic [31:0]   Rs1, Rs2, res_pc;
  logic          res_pred;
  logic          res_valid, Branch_taken, mispredict, illegal;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  typedef struct packed {
    logic          bt;
    logic          mp;
    logic          ill;
    logic [CW-1:0] bc;
    logic [CW-1:0] mc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [1:0]    bht_m [64];
  logic [CW-1:0] bc_m, mc_m;
  logic          last_bt, last_mp, last_ill;
  int            total = 0;
  int            bad = 0;

  branch_resolve_bht #(
    .XLEN(32), .FUNCT3(3), .BHT_DEPTH(64), .IDX_LSB(2), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .En(En), .funct3(funct3), .Rs1(Rs1), .Rs2(Rs2), .res_pc(res_pc),
    .res_pred(res_pred), .res_valid(res_valid), .Branch_taken(Branch_taken),
    .mispredict(mispredict), .illegal(illegal), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns {illegal, taken} using native SystemVerilog comparisons.
  function automatic logic [1:0] model_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return {1'b0, a == b};
      3'b001:  return {1'b0, a != b};
      3'b100:  return {1'b0, $signed(a) <  $signed(b)};
      3'b101:  return {1'b0, $signed(a) >= $signed(b)};
      3'b110:  return {1'b0, a <  b};
      3'b111:  return {1'b0, a >= b};
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic mpred(input logic [31:0] pc);
    return bht_m[pc[7:2]][1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
    bc_m = '0;
    mc_m = '0;
    last_bt = 1'b0;
    last_mp = 1'b0;
    last_ill = 1'b0;
    exp_q.delete();
  endtask

  task automatic resolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic p);
    logic [1:0] r;
    logic [5:0] ix;
    exp_t       e;
    @(negedge CLK);
    En = 1'b1; funct3 = f3; Rs1 = a; Rs2 = b; res_pc = pc; res_pred = p;
    r  = model_br(f3, a, b);
    ix = pc[7:2];
    if (r[1]) begin
      e.bt = 1'b0; e.mp = 1'b0; e.ill = 1'b1;
    end else begin
      e.bt = r[0]; e.mp = r[0] ^ p; e.ill = 1'b0;
      bc_m = bc_m + 4'd1;
      if (e.mp) mc_m = mc_m + 4'd1;
      if (r[0] && bht_m[ix] != 2'b11) bht_m[ix] = bht_m[ix] + 2'd1;
      else if (!r[0] && bht_m[ix] != 2'b00) bht_m[ix] = bht_m[ix] - 2'd1;
    end
    e.bc = bc_m;
    e.mc = mc_m;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge CLK);
    En = 1'b0;
  endtask

  // Output monitor: pop and compare on res_valid, otherwise check held values
  always @(negedge CLK) begin
    if (rst_n) begin
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", res_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("branch_taken", Branch_taken, mon_e.bt);
          check("mispredict", mispredict, mon_e.mp);
          check("illegal", illegal, mon_e.ill);
          check("branch_cnt", branch_cnt, mon_e.bc);
          check("mispred_cnt", mispred_cnt, mon_e.mc);
          last_bt = mon_e.bt; last_mp = mon_e.mp; last_ill = mon_e.ill;
        end
      end else begin
        check("hold_bt", Branch_taken, last_bt);
        check("hold_mp", mispredict, last_mp);
        check("hold_ill", illegal, last_ill);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] legal_f3 [6];
    legal_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    rst_n = 1'b0; En = 1'b0; funct3 = 3'b000; Rs1 = '0; Rs2 = '0;
    res_pc = '0; res_pred = 1'b0; pred_pc = 32'h100;
    model_reset();
    repeat (2) @(negedge CLK);
    check("rst_valid", res_valid, 1'b0);
    check("rst_bt", Branch_taken, 1'b0);
    check("rst_mp", mispredict, 1'b0);
    check("rst_ill", illegal, 1'b0);
    check("rst_bcnt", branch_cnt, 4'd0);
    check("rst_mcnt", mispred_cnt, 4'd0);
    check("rst_pred_100", pred_taken, 1'b0);
    rst_n = 1'b1;

    // BEQ equal operands, predicted not taken
    resolve(3'b000, 32'd5, 32'd5, 32'h200, 1'b0);
    idle();
    #1 check("beq_cnt", branch_cnt, 4'd1);

    // Signed versus unsigned with 0xFFFFFFFF and 1, back to back
    resolve(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0);
    resolve(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h304, 1'b0);
    resolve(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h308, 1'b0);
    resolve(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h30C, 1'b0);
    idle();

    // Saturation on PC 0x40
    pred_pc = 32'h40;
    for (int i = 0; i < 4; i++) resolve(3'b000, 32'd1, 32'd1, 32'h40, mpred(32'h40));
    idle();
    #1 check("sat_st_pred", pred_taken, 1'b1);
    check("sat_st_model", pred_taken, mpred(32'h40));
    resolve(3'b001, 32'd1, 32'd1, 32'h40, mpred(32'h40));
    idle();
    #1 check("sat_wt_pred", pred_taken, 1'b1);
    for (int i = 0; i < 3; i++) resolve(3'b001, 32'd1, 32'd1, 32'h40, mpred(32'h40));
    idle();
    #1 check("sat_snt_pred", pred_taken, 1'b0);

    // Same-index lookup and update at 0x80
    resolve(3'b000, 32'd9, 32'd9, 32'h80, 1'b0);
    pred_pc = 32'h80;
    #1 check("same_idx_pre", pred_taken, 1'b0);
    idle();
    #1 check("same_idx_post", pred_taken, 1'b1);

    // Reserved funct3 codes leave BHT and counters alone
    resolve(3'b010, 32'd3, 32'd3, 32'h80, 1'b0);
    resolve(3'b011, 32'd4, 32'd4, 32'h80, 1'b1);
    idle();
    #1 check("illegal_bht_kept", pred_taken, 1'b1);

    // Reset in the cycle after a request discards the pending result
    resolve(3'b000, 32'd7, 32'd7, 32'h40, 1'b0);
    @(posedge CLK);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("midrst_valid", res_valid, 1'b0);
    check("midrst_bt", Branch_taken, 1'b0);
    check("midrst_bcnt", branch_cnt, 4'd0);
    check("midrst_mcnt", mispred_cnt, 4'd0);
    check("midrst_pred_80", pred_taken, 1'b0);
    pred_pc = 32'h300;
    #1 check("midrst_pred_300", pred_taken, 1'b0);
    @(negedge CLK);
    En = 1'b0;
    rst_n = 1'b1;

    // Random legal branches from cold: 17 resolves wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      resolve(legal_f3[$urandom_range(0, 5)], 32'($urandom_range(0, 3)),
              32'($urandom_range(0, 3)), 32'(i * 4), 1'($urandom_range(0, 1)));
    end
    idle();
    #1 check("wrap_bcnt", branch_cnt, 4'd1);
    pred_pc = 32'h8;
    #1 check("post_rand_pred", pred_taken, mpred(32'h8));

    repeat (2) idle();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
